// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
//   Bundles the two handshake buses of the fetch stage:
//     imem_req_*  : request channel to instruction memory (valid/ready + addr)
//     imem_rsp_*  : in-order read-data return from instruction memory
//     inst_*      : instruction hand-off to decode (valid/ready + word/pc/fault)
//   master : fetch-stage view (drives requests and instructions to decode)
//   slave  : memory/decode view
// ---------------------------------------------------------------------------
interface instruction_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc, inst_fault,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc, inst_fault,
    output inst_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage behind the program counter. Issues in-order instruction
//   memory requests at pc_in, pulses pc_advance on every accepted request,
//   queues returned words together with their PC and hands them to decode.
//   A flush discards queued entries and marks in-flight requests as dropped.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   pc_in       current PC value (request address)
//   pc_advance  PC count-enable, high in cycles a request is accepted
//   flush       redirect; PC is rewritten in the same cycle
//   busy        requests outstanding (live or dropped) or queue non-empty
//   bus         instruction_fetch_if.master (imem request/response, decode)
//
// Optional feature
//   FETCH_MISALIGN_TRAP_EN : a misaligned pc_in (pc_in[1:0] != 0) with no
//   live request produces a fault entry {pc_in, 0, fault=1} instead of a
//   memory request and halts issue until the next flush.
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int QUEUE_DEPTH     = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pc_in,
  output logic                pc_advance,
  input  logic                flush,
  output logic                busy,
  instruction_fetch_if.master bus
);

  localparam int QIW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int QCW = $clog2(QUEUE_DEPTH) + 1;
  localparam int TIW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING) + 1;

  // instruction queue (power-of-2 depth, pointers wrap naturally)
  logic [31:0]    q_data_q [QUEUE_DEPTH];
  logic [31:0]    q_pc_q   [QUEUE_DEPTH];
  logic [QIW-1:0] q_wr_q, q_rd_q;
  logic [QCW-1:0] q_cnt_q, q_cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic           q_fault_q [QUEUE_DEPTH];
`endif

  // PC tags of live requests, in issue order
  logic [31:0]    tag_q [MAX_OUTSTANDING];
  logic [TIW-1:0] tag_wr_q, tag_rd_q;

  logic [OCW-1:0] live_q, live_d;
  logic [OCW-1:0] drop_q, drop_d;
  logic           halt_q, halt_d;

  logic issue_ok, misaligned, req_valid, trap, accept;
  logic rsp_any, rsp_drop, rsp_keep, q_push, q_pop, q_nonempty;

  // tag FIFO depth need not be a power of 2
  function automatic logic [TIW-1:0] tag_next(input logic [TIW-1:0] p);
    if (int'(p) == MAX_OUTSTANDING - 1) tag_next = '0;
    else                                tag_next = p + TIW'(1);
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = (pc_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Credits count dropped requests against the memory limit and live requests
  // against queue space, so an accepted response always has a queue slot.
  assign issue_ok   = !reset && !flush && !halt_q &&
                      (int'(live_q) + int'(drop_q)  < MAX_OUTSTANDING) &&
                      (int'(live_q) + int'(q_cnt_q) < QUEUE_DEPTH);
  assign req_valid  = issue_ok && !misaligned;
  assign trap       = issue_ok && misaligned && (live_q == '0);
  assign accept     = req_valid && bus.imem_req_ready;

  assign rsp_any    = bus.imem_rsp_valid && ((live_q != '0) || (drop_q != '0));
  assign rsp_drop   = bus.imem_rsp_valid && (drop_q != '0);
  assign rsp_keep   = bus.imem_rsp_valid && (drop_q == '0) && (live_q != '0);

  assign q_nonempty = !reset && (q_cnt_q != '0);
  assign q_push     = rsp_keep || trap;
  assign q_pop      = q_nonempty && bus.inst_ready;

  always_comb begin
    live_d  = live_q;
    drop_d  = drop_q;
    halt_d  = halt_q;
    q_cnt_d = q_cnt_q;
    if (flush) begin
      // a response landing in the flush cycle retires one pre-flush request
      live_d  = '0;
      drop_d  = drop_q + live_q - OCW'(rsp_any);
      halt_d  = 1'b0;
      q_cnt_d = '0;
    end else begin
      live_d  = live_q + OCW'(accept) - OCW'(rsp_keep);
      drop_d  = drop_q - OCW'(rsp_drop);
      halt_d  = halt_q | trap;
      q_cnt_d = q_cnt_q + QCW'(q_push) - QCW'(q_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_wr_q   <= '0;
      q_rd_q   <= '0;
      q_cnt_q  <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      live_q   <= '0;
      drop_q   <= '0;
      halt_q   <= 1'b0;
    end else begin
      live_q  <= live_d;
      drop_q  <= drop_d;
      halt_q  <= halt_d;
      q_cnt_q <= q_cnt_d;
      if (flush) begin
        q_wr_q   <= '0;
        q_rd_q   <= '0;
        tag_wr_q <= '0;
        tag_rd_q <= '0;
      end else begin
        if (accept) begin
          tag_q[tag_wr_q] <= pc_in;
          tag_wr_q        <= tag_next(tag_wr_q);
        end
        if (rsp_keep) tag_rd_q <= tag_next(tag_rd_q);
        if (q_push) begin
          q_data_q[q_wr_q]  <= trap ? 32'h0 : bus.imem_rsp_data;
          q_pc_q[q_wr_q]    <= trap ? pc_in : tag_q[tag_rd_q];
`ifdef FETCH_MISALIGN_TRAP_EN
          q_fault_q[q_wr_q] <= trap;
`endif
          q_wr_q            <= q_wr_q + QIW'(1);
        end
        if (q_pop) q_rd_q <= q_rd_q + QIW'(1);
      end
    end
  end

  assign pc_advance         = accept;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = reset ? 32'h0 : pc_in;
  assign bus.inst_valid     = q_nonempty;
  assign bus.inst_data      = q_nonempty ? q_data_q[q_rd_q] : 32'h0;
  assign bus.inst_pc        = q_nonempty ? q_pc_q[q_rd_q]   : 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.inst_fault     = q_nonempty && q_fault_q[q_rd_q];
`else
  assign bus.inst_fault     = 1'b0;
`endif
  assign busy = !reset && ((live_q != '0) || (drop_q != '0) || (q_cnt_q != '0));

endmodule
